// File: rtl/tl_pkg.sv
// tl_pkg: phase encodings, mode codes and timed-phase durations shared by the signal controller blocks.
package tl_pkg;
  typedef enum logic [3:0] {
    S_NS_GREEN  = 4'd0,
    S_NS_YELLOW = 4'd1,
    S_ALL_RED_A = 4'd2,
    S_EW_GREEN  = 4'd3,
    S_EW_YELLOW = 4'd4,
    S_ALL_RED_B = 4'd5,
    S_FLASH     = 4'd6
  } phase_t;
  localparam logic [1:0] MODE_FIX   = 2'b00;
  localparam logic [1:0] MODE_ACT   = 2'b01;
  localparam logic [1:0] MODE_FLASH = 2'b10;
  function automatic logic [7:0] phase_dur(phase_t p, logic [7:0] t_green, logic [7:0] t_yellow,
                                           logic [7:0] t_all_red);
    return (p == S_NS_YELLOW || p == S_EW_YELLOW) ? t_yellow :
           (p == S_ALL_RED_A || p == S_ALL_RED_B) ? t_all_red : t_green;
  endfunction
endpackage

// File: rtl/actuated_phase_ctrl_if.sv
// actuated_phase_ctrl_if: tick/mode/demand inputs and phase/lamp outputs of the phase sequencer.
interface actuated_phase_ctrl_if;
  logic       tick_1s;
  logic [1:0] mode_sel;
  logic       veh_NS;
  logic       veh_EW;
  logic [3:0] phase_id;
  logic       phase_start;
  logic [7:0] phase_sec;
  logic       ns_r, ns_y, ns_g;
  logic       ew_r, ew_y, ew_g;
  modport master (
    output tick_1s, mode_sel, veh_NS, veh_EW,
    input  phase_id, phase_start, phase_sec, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g
  );
  modport slave (
    input  tick_1s, mode_sel, veh_NS, veh_EW,
    output phase_id, phase_start, phase_sec, ns_r, ns_y, ns_g, ew_r, ew_y, ew_g
  );
endinterface

// File: rtl/tl_lamp_decode.sv
// tl_lamp_decode: pure decode of phase and flash toggle into the six NS/EW lamps.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  phase_t phase_id,
  input  logic   tog,
  output logic   ns_r,
  output logic   ns_y,
  output logic   ns_g,
  output logic   ew_r,
  output logic   ew_y,
  output logic   ew_g
);
  always_comb begin
    ns_g = phase_id == S_NS_GREEN;
    ns_y = phase_id == S_NS_YELLOW || (phase_id == S_FLASH && tog);
    ns_r = phase_id != S_FLASH && !ns_g && !ns_y;
    ew_g = phase_id == S_EW_GREEN;
    ew_y = phase_id == S_EW_YELLOW || (phase_id == S_FLASH && tog);
    ew_r = phase_id != S_FLASH && !ew_g && !ew_y;
  end
endmodule

// File: rtl/actuated_phase_ctrl.sv
// actuated_phase_ctrl: fixed/actuated/flash intersection phase sequencer driven by a 1 Hz tick.
module actuated_phase_ctrl
  import tl_pkg::*;
#(
  parameter int T_GREEN_FIX = 20,
  parameter int T_GREEN_MIN = 10,
  parameter int T_GREEN_MAX = 40,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2
) (
  input logic                  clk,
  input logic                  rst,
  actuated_phase_ctrl_if.slave bus
);
  phase_t     ph, ph_nxt, seq;
  logic [7:0] sec, sec_nxt;
  logic       tog, tog_nxt, start;
  logic       green, own, oth, act_end, timed_end, done, trans;
  always_comb begin
    green     = ph == S_NS_GREEN || ph == S_EW_GREEN;
    own       = ph == S_NS_GREEN ? bus.veh_NS : bus.veh_EW;
    oth       = ph == S_NS_GREEN ? bus.veh_EW : bus.veh_NS;
    act_end   = sec >= 8'(T_GREEN_MIN - 1) && oth && (!own || sec >= 8'(T_GREEN_MAX - 1));
    timed_end = sec == phase_dur(ph, 8'(T_GREEN_FIX), 8'(T_YELLOW), 8'(T_ALL_RED)) - 8'd1;
    done      = bus.tick_1s && ((green && bus.mode_sel == MODE_ACT) ? act_end : timed_end);
    seq       = ph == S_ALL_RED_B ? S_NS_GREEN : phase_t'(ph + 4'd1);
    // flash entry/exit is immediate, independent of the tick
    ph_nxt    = bus.mode_sel[1] ? S_FLASH : ph == S_FLASH ? S_ALL_RED_B : done ? seq : ph;
    trans     = ph_nxt != ph;
    sec_nxt   = trans ? 8'd0 : (bus.tick_1s && sec != 8'hFF) ? sec + 8'd1 : sec;
    tog_nxt   = trans ? 1'b0 : (ph == S_FLASH && bus.tick_1s) ? ~tog : tog;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph    <= S_NS_GREEN;
      sec   <= 8'd0;
      tog   <= 1'b0;
      start <= 1'b0;
    end else begin
      ph    <= ph_nxt;
      sec   <= sec_nxt;
      tog   <= tog_nxt;
      start <= trans;
    end
  end
  assign bus.phase_id    = ph;
  assign bus.phase_sec   = sec;
  assign bus.phase_start = start;
  tl_lamp_decode u_lamps (
    .phase_id (ph),
    .tog      (tog),
    .ns_r     (bus.ns_r),
    .ns_y     (bus.ns_y),
    .ns_g     (bus.ns_g),
    .ew_r     (bus.ew_r),
    .ew_y     (bus.ew_y),
    .ew_g     (bus.ew_g)
  );
endmodule

// File: tb/tb_actuated_phase_ctrl.sv
// tb_actuated_phase_ctrl: table vectors, scenario sequences and random stimulus against a reference model.
module tb_actuated_phase_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  actuated_phase_ctrl_if bus ();
  actuated_phase_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int m_ph, m_sec, m_tog, m_start;
  localparam int DUR[6] = '{20, 3, 2, 20, 3, 2};
  typedef struct {
    bit         r, t;
    logic [1:0] m;
    int         ph, sec, st;
    logic [5:0] lp;
  } vec_t;
  vec_t tbl[12];
  function automatic logic [5:0] exp_lamps(int ph, int tog);
    case (ph)
      0: return 6'b001100;
      1: return 6'b010100;
      2: return 6'b100100;
      3: return 6'b100001;
      4: return 6'b100010;
      5: return 6'b100100;
      default: return tog != 0 ? 6'b010010 : 6'b000000;
    endcase
  endfunction
  function automatic logic [5:0] lamps();
    return {bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g};
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic enter(int ph);
    m_ph = ph; m_sec = 0; m_start = 1; m_tog = 0;
  endtask
  task automatic model(bit r, bit t, logic [1:0] m, bit n, bit e);
    bit own, oth, fin;
    m_start = 0;
    if (r) begin
      m_ph = 0; m_sec = 0; m_tog = 0;
    end else if (m[1] && m_ph != 6) enter(6);
    else if (!m[1] && m_ph == 6) enter(5);
    else if (t) begin
      if (m_ph == 6) fin = 0;
      else if ((m_ph == 0 || m_ph == 3) && m == 2'b01) begin
        own = m_ph == 0 ? n : e;
        oth = m_ph == 0 ? e : n;
        fin = m_sec >= 9 && oth && (!own || m_sec >= 39);
      end else fin = m_sec == DUR[m_ph] - 1;
      if (m_ph == 6) m_tog = 1 - m_tog;
      if (fin) enter((m_ph + 1) % 6);
      else m_sec = m_sec < 255 ? m_sec + 1 : 255;
    end
  endtask
  task automatic cyc(bit r, bit t, logic [1:0] m, bit n, bit e);
    rst = r; bus.tick_1s = t; bus.mode_sel = m; bus.veh_NS = n; bus.veh_EW = e;
    @(posedge clk);
    model(r, t, m, n, e);
    #1;
    chk("phase_id", int'(bus.phase_id), m_ph);
    chk("phase_sec", int'(bus.phase_sec), m_sec);
    chk("phase_start", int'(bus.phase_start), m_start);
    chk("lamps", int'(lamps()), int'(exp_lamps(m_ph, m_tog)));
  endtask
  task automatic tk(logic [1:0] m, bit n, bit e);
    cyc(0, 1, m, n, e);
    cyc(0, 0, m, n, e);
  endtask
  initial begin
    int cnt[6];
    int starts, bad, prev, s, n;
    bit vn, ve;
    logic [1:0] md;
    tbl[0]  = '{1, 0, 2'd0, 0, 0, 0, 6'b001100};
    tbl[1]  = '{0, 1, 2'd0, 0, 1, 0, 6'b001100};
    tbl[2]  = '{0, 0, 2'd0, 0, 1, 0, 6'b001100};
    tbl[3]  = '{0, 1, 2'd2, 6, 0, 1, 6'b000000};
    tbl[4]  = '{0, 1, 2'd2, 6, 1, 0, 6'b010010};
    tbl[5]  = '{0, 0, 2'd3, 6, 1, 0, 6'b010010};
    tbl[6]  = '{0, 1, 2'd3, 6, 2, 0, 6'b000000};
    tbl[7]  = '{0, 0, 2'd1, 5, 0, 1, 6'b100100};
    tbl[8]  = '{0, 1, 2'd1, 5, 1, 0, 6'b100100};
    tbl[9]  = '{0, 1, 2'd1, 0, 0, 1, 6'b001100};
    tbl[10] = '{0, 0, 2'd1, 0, 0, 0, 6'b001100};
    tbl[11] = '{1, 1, 2'd2, 0, 0, 0, 6'b001100};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].m, 0, 0);
      chk("tbl_phase", int'(bus.phase_id), tbl[i].ph);
      chk("tbl_sec", int'(bus.phase_sec), tbl[i].sec);
      chk("tbl_start", int'(bus.phase_start), tbl[i].st);
      chk("tbl_lamps", int'(lamps()), int'(tbl[i].lp));
    end
    // fixed-time cycle: dwell per phase and one start pulse per phase
    cyc(1, 0, 2'd0, 0, 0);
    cnt = '{default: 0};
    starts = 0; bad = 0; prev = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.phase_id < 6) cnt[bus.phase_id]++;
      cyc(0, 1, 2'd0, 0, 0);
      if (bus.phase_start) begin
        starts++;
        if (int'(bus.phase_id) != (prev + 1) % 6) bad++;
        prev = bus.phase_id;
      end
      cyc(0, 0, 2'd0, 0, 0);
    end
    for (int k = 0; k < 6; k++) chk("fix_dwell", cnt[k], 2 * DUR[k]);
    chk("fix_starts", starts, 12);
    chk("fix_order", bad, 0);
    chk("fix_end_phase", int'(bus.phase_id), 0);
    // actuated rest in green with saturation
    cyc(1, 0, 2'd1, 1, 0);
    for (int i = 0; i < 260; i++) tk(2'd1, 1, 0);
    chk("rest_phase", int'(bus.phase_id), 0);
    chk("rest_sat", int'(bus.phase_sec), 255);
    // conflicting request arriving at second 3 ends green at min green
    cyc(1, 0, 2'd1, 0, 0);
    for (int i = 0; i < 3; i++) tk(2'd1, 0, 0);
    chk("req_sec3", int'(bus.phase_sec), 3);
    s = -1;
    for (int i = 0; i < 40; i++) begin
      s = bus.phase_sec;
      tk(2'd1, 0, 1);
      if (bus.phase_id != 0) break;
    end
    chk("req_leave_sec", s, 9);
    chk("req_leave_phase", int'(bus.phase_id), 1);
    // both demands held: max green each way
    cyc(1, 0, 2'd1, 1, 1);
    n = 0;
    for (int i = 0; i < 300 && bus.phase_id == 0; i++) begin tk(2'd1, 1, 1); n++; end
    chk("max_ns", n, 40);
    for (int i = 0; i < 20 && bus.phase_id != 3; i++) tk(2'd1, 1, 1);
    n = 0;
    for (int i = 0; i < 300 && bus.phase_id == 3; i++) begin tk(2'd1, 1, 1); n++; end
    chk("max_ew", n, 40);
    for (int i = 0; i < 100 && bus.phase_id != 3; i++) tk(2'd1, 1, 1);
    tk(2'd1, 1, 1);
    chk("pre_flash_phase", int'(bus.phase_id), 3);
    cyc(0, 0, 2'd2, 1, 1);
    chk("flash_entry", int'(bus.phase_id), 6);
    chk("flash_start", int'(bus.phase_start), 1);
    tk(2'd2, 1, 1);
    chk("flash_ns_y1", int'(bus.ns_y), 1);
    chk("flash_ew_y1", int'(bus.ew_y), 1);
    tk(2'd2, 1, 1);
    chk("flash_ns_y0", int'(bus.ns_y), 0);
    cyc(0, 0, 2'd1, 1, 1);
    chk("flash_exit", int'(bus.phase_id), 5);
    tk(2'd1, 1, 1);
    chk("exit_red1", int'(bus.phase_id), 5);
    tk(2'd1, 1, 1);
    chk("exit_green", int'(bus.phase_id), 0);
    // reset coincident with tick during NS yellow
    cyc(1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 20; i++) tk(2'd0, 0, 0);
    chk("yel_phase", int'(bus.phase_id), 1);
    cyc(1, 1, 2'd0, 0, 0);
    chk("rst_phase", int'(bus.phase_id), 0);
    chk("rst_sec", int'(bus.phase_sec), 0);
    chk("rst_ns_g", int'(bus.ns_g), 1);
    chk("rst_ew_r", int'(bus.ew_r), 1);
    // random stimulus
    cyc(1, 0, 2'd1, 0, 0);
    md = 2'd1; vn = 0; ve = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(99) == 0) md = 2'($urandom_range(3));
      else if ($urandom_range(49) == 0) md = 2'($urandom_range(1));
      if ($urandom_range(29) == 0) vn = ~vn;
      if ($urandom_range(29) == 0) ve = ~ve;
      cyc($urandom_range(799) == 0, $urandom_range(2) == 0, md, vn, ve);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
